// File: rtl/regbank_pkg.sv
// Shared types and default sizes for the two-requester register bank arbiter.
// Imported by the storage core and by the arbiter top.
package regbank_pkg;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_ADDR_W    = 3;
    localparam int DEF_MAX_BURST = 4;

    // Records who owned the bank in the previous cycle.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } own_state_t;

endpackage

// File: rtl/regbank_core.sv
// Flop-based register bank: one write port and one registered read port.
// Every word clears on reset so that a restart never exposes stale contents.
module regbank_core
    import regbank_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the array sits inside the reset branch on purpose; the bank has to read
    // as all-zero right after reset, which rules out a RAM macro but suits a flop bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rdata <= '0;
        end else begin
            if (we) begin
                mem[waddr] <= wdata;
            end
            if (re) begin
                rdata <= mem[raddr];
            end
        end
    end

endmodule

// File: rtl/regbank_arbiter.sv
// Two-requester arbiter in front of regbank_core with a rotating priority pointer
// and bounded lock bursts; accesses execute in the grant cycle.
module regbank_arbiter
    import regbank_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req,
    input  logic [1:0]        lock,
    input  logic [1:0]        we,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [1:0]        gnt,
    output logic [1:0]        rvalid,
    output logic [DATA_W-1:0] rdata
);

    localparam int              CNT_W      = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

    own_state_t        state, state_nxt;
    logic              prio, prio_nxt;
    logic [CNT_W-1:0]  burst_cnt, burst_nxt, run;
    logic              rd_pend, rd_pend_nxt;
    logic              granted, gidx;
    logic              core_we, core_re;
    logic [ADDR_W-1:0] gaddr;
    logic [DATA_W-1:0] gwdata;

    // Grant is gated by rst_n so it drops the instant reset asserts.
    always_comb begin
        gnt = 2'b00;
        if (rst_n) begin
            if (req == 2'b11) begin
                gnt = prio ? 2'b10 : 2'b01;
            end else begin
                gnt = req;
            end
        end
    end

    assign granted = |gnt;
    assign gidx    = gnt[1];
    assign gaddr   = gidx ? addr1 : addr0;
    assign gwdata  = gidx ? wdata1 : wdata0;
    assign core_we = granted & we[gidx];
    assign core_re = granted & ~we[gidx];

    // NOTE: every signal driven here gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_nxt   = IDLE;
        prio_nxt    = prio;
        burst_nxt   = burst_cnt;
        rd_pend_nxt = 1'b0;
        run         = '0;
        rvalid      = 2'b00;

        if (rd_pend) begin
            case (state)
                OWN0:    rvalid = 2'b01;
                OWN1:    rvalid = 2'b10;
                default: rvalid = 2'b00;
            endcase
        end

        if (granted) begin
            state_nxt   = gidx ? OWN1 : OWN0;
            rd_pend_nxt = ~we[gidx];
            // A grant to the non-priority side is an owner change: its burst starts from zero.
            run = (gidx == prio) ? burst_cnt : '0;
            if (lock[gidx] && (run < BURST_LAST)) begin
                prio_nxt  = gidx;
                burst_nxt = run + 1'b1;
            end else begin
                prio_nxt  = ~gidx;
                burst_nxt = '0;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            prio      <= 1'b0;
            burst_cnt <= '0;
            rd_pend   <= 1'b0;
        end else begin
            state     <= state_nxt;
            prio      <= prio_nxt;
            burst_cnt <= burst_nxt;
            rd_pend   <= rd_pend_nxt;
        end
    end

    regbank_core #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_core (
        .clk  (clk),
        .rst_n(rst_n),
        .we   (core_we),
        .waddr(gaddr),
        .wdata(gwdata),
        .re   (core_re),
        .raddr(gaddr),
        .rdata(rdata)
    );

endmodule
